// File: rtl/binary_frame_buffer_if.sv
// rtl/binary_frame_buffer_if.sv - pixel stream, filter read port and filter control bundle
interface binary_frame_buffer_if;
   logic [7:0] pixIn;
   logic       pixValid;
   logic       pixReady;
   logic       sof;
   logic [7:0] rdX;
   logic [7:0] rdY;
   logic       rdData;
   logic       filterInit;
   logic       filterStart;
   logic       filterDone;
   logic [7:0] framesDropped;

   modport master (
      output pixIn, pixValid, sof, rdX, rdY, filterDone,
      input  pixReady, rdData, filterInit, filterStart, framesDropped
   );

   modport slave (
      input  pixIn, pixValid, sof, rdX, rdY, filterDone,
      output pixReady, rdData, filterInit, filterStart, framesDropped
   );
endinterface

// File: rtl/binary_frame_buffer.sv
// rtl/binary_frame_buffer.sv - binarizing ping-pong frame store that sequences the median filter
module binary_frame_buffer #(
   parameter int IMAGEWIDTH  = 240,
   parameter int IMAGEHEIGHT = 180,
   parameter int THRESHOLD   = 128
) (
   input logic                  clk,
   input logic                  reset,
   binary_frame_buffer_if.slave bus
);
   localparam int PIX = IMAGEWIDTH * IMAGEHEIGHT;
   localparam int AW  = $clog2(PIX);
   localparam logic [7:0] X_LAST = 8'(IMAGEWIDTH - 1);
   localparam logic [7:0] Y_LAST = 8'(IMAGEHEIGHT - 1);
   localparam logic [7:0] X_LIM  = 8'(IMAGEWIDTH);
   localparam logic [7:0] Y_LIM  = 8'(IMAGEHEIGHT);
   localparam logic [7:0] THR    = 8'(THRESHOLD);

   typedef enum logic [0:0] {WR_FILL, WR_WAIT} wr_state_e;
   typedef enum logic [1:0] {RD_IDLE, RD_INIT, RD_RUN, RD_DRAIN} rd_state_e;

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;
   logic       wr_bank_q, wr_bank_d;
   logic       rd_bank_q, rd_bank_d;
   logic [1:0] full_q, full_d;
   logic       last_full_q, last_full_d;
   logic [7:0] wr_x_q, wr_x_d;
   logic [7:0] wr_y_q, wr_y_d;
   logic [7:0] dropped_q, dropped_d;
   logic       rd_data_q, rd_data_d;

   logic          frame_ram [2][PIX];
   logic          transfer;
   logic          wr_en;
   logic          wr_bit;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] cur_addr;
   logic [AW-1:0] rd_addr;
   logic          rd_in_range;
   logic          release_now;
   logic [1:0]    full_rel;

   assign bus.pixReady      = (wr_state_q == WR_FILL) && !reset;
   assign bus.filterInit    = (rd_state_q == RD_INIT) && !reset;
   assign bus.filterStart   = ((rd_state_q == RD_RUN) || (rd_state_q == RD_DRAIN)) && !reset;
   assign bus.rdData        = rd_data_q;
   assign bus.framesDropped = dropped_q;

   assign transfer = bus.pixValid && bus.pixReady;
   assign wr_bit   = (bus.pixIn >= THR);
   assign cur_addr = AW'(wr_y_q) * AW'(IMAGEWIDTH) + AW'(wr_x_q);
   assign rd_addr  = AW'(bus.rdY) * AW'(IMAGEWIDTH) + AW'(bus.rdX);
   assign rd_in_range = (bus.rdX < X_LIM) && (bus.rdY < Y_LIM);

   always_comb begin
      wr_state_d  = wr_state_q;
      rd_state_d  = rd_state_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      last_full_d = last_full_q;
      wr_x_d      = wr_x_q;
      wr_y_d      = wr_y_q;
      dropped_d   = dropped_q;
      wr_en       = 1'b0;
      wr_addr     = cur_addr;

      // A bank released this cycle is already free for a writer finishing this cycle.
      release_now = (rd_state_q == RD_DRAIN);
      full_rel    = full_q;
      if (release_now) full_rel[rd_bank_q] = 1'b0;
      full_d = full_rel;

      case (wr_state_q)
         WR_FILL: begin
            if (transfer) begin
               wr_en = 1'b1;
               if (bus.sof && ((wr_x_q != 8'd0) || (wr_y_q != 8'd0))) begin
                  wr_addr = '0;
                  wr_x_d  = 8'd1;
                  wr_y_d  = 8'd0;
                  if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
               end else if ((wr_x_q == X_LAST) && (wr_y_q == Y_LAST)) begin
                  full_d[wr_bank_q] = 1'b1;
                  last_full_d       = wr_bank_q;
                  wr_x_d            = 8'd0;
                  wr_y_d            = 8'd0;
                  if (!full_rel[~wr_bank_q]) wr_bank_d = ~wr_bank_q;
                  else wr_state_d = WR_WAIT;
               end else if (wr_x_q == X_LAST) begin
                  wr_x_d = 8'd0;
                  wr_y_d = wr_y_q + 8'd1;
               end else begin
                  wr_x_d = wr_x_q + 8'd1;
               end
            end
         end
         WR_WAIT: begin
            if (!full_rel[~wr_bank_q]) begin
               wr_bank_d  = ~wr_bank_q;
               wr_state_d = WR_FILL;
            end
         end
         default: wr_state_d = WR_FILL;
      endcase

      case (rd_state_q)
         RD_IDLE: begin
            if (|full_q) begin
               rd_bank_d  = (&full_q) ? ~last_full_q : full_q[1];
               rd_state_d = RD_INIT;
            end
         end
         RD_INIT:  rd_state_d = RD_RUN;
         RD_RUN:   if (bus.filterDone) rd_state_d = RD_DRAIN;
         RD_DRAIN: rd_state_d = RD_IDLE;
         default:  rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_data_d = 1'b0;
      if (rd_in_range) rd_data_d = frame_ram[rd_bank_q][rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state_q  <= WR_FILL;
         rd_state_q  <= RD_IDLE;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         full_q      <= 2'b00;
         last_full_q <= 1'b0;
         wr_x_q      <= 8'd0;
         wr_y_q      <= 8'd0;
         dropped_q   <= 8'd0;
         rd_data_q   <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         rd_state_q  <= rd_state_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         last_full_q <= last_full_d;
         wr_x_q      <= wr_x_d;
         wr_y_q      <= wr_y_d;
         dropped_q   <= dropped_d;
         rd_data_q   <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) frame_ram[wr_bank_q][wr_addr] <= wr_bit;
   end
endmodule

// File: tb/tb_binary_frame_buffer.sv
// tb/tb_binary_frame_buffer.sv - scoreboard bench for binary_frame_buffer
module tb_binary_frame_buffer;
   localparam int W   = 24;
   localparam int H   = 22;
   localparam int PIX = W * H;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   binary_frame_buffer_if bus ();

   binary_frame_buffer #(.IMAGEWIDTH(W), .IMAGEHEIGHT(H), .THRESHOLD(128)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   vectors = 0;
   int   miscompares = 0;
   logic rd_exp_q [$];
   int   init_exp_q [$];
   logic rd_issue = 1'b0;
   logic rd_tag_q = 1'b0;
   logic prev_init = 1'b0;
   int   init_seen = 0;
   logic done_force = 1'b0;
   logic auto_done = 1'b0;
   int   run_cnt = 0;
   int   done_after = 1000000;

   assign bus.filterDone = done_force | auto_done;

   function automatic void check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] pix_val(input int pat, input int x, input int y);
      case (pat)
         0: begin
            if (x == 10 && y == 20) return 8'd200;
            if (x == 2 && y == 3) return 8'd127;
            if (x == 3 && y == 3) return 8'd128;
            return 8'd0;
         end
         1: return 8'((x * 7 + y * 13) % 256);
         2: return (x >= y) ? 8'd255 : 8'd0;
         default: return 8'((x * 29 + y * 3 + 5) % 256);
      endcase
   endfunction

   function automatic logic exp_read(input int pat, input int x, input int y);
      if (x >= W || y >= H) return 1'b0;
      return pix_val(pat, x, y) >= 8'd128;
   endfunction

   task automatic give_up(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting for the DUT", name);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "bench stopped on timeout");
   endtask

   // filter stand-in: counts run cycles, raises a sticky done after done_after of them
   always @(posedge clk) begin
      if (reset || bus.filterInit) begin
         run_cnt   <= 0;
         auto_done <= 1'b0;
      end else if (bus.filterStart) begin
         run_cnt <= run_cnt + 1;
         if (run_cnt >= done_after) auto_done <= 1'b1;
      end
   end

   always @(posedge clk) rd_tag_q <= rd_issue;

   always @(negedge clk) begin
      if (rd_tag_q) begin
         if (rd_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_scoreboard: read returned with no expected value queued");
         end else begin
            check("rdData", int'(bus.rdData), int'(rd_exp_q.pop_front()));
         end
      end
      if (prev_init) begin
         check("init_width", int'(bus.filterInit), 0);
         check("start_after_init", int'(bus.filterStart), 1);
      end
      if (bus.filterInit && !reset) begin
         init_seen <= init_seen + 1;
         check("init_start_low", int'(bus.filterStart), 0);
         if (init_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL init_unexpected: filterInit=1 with no completed frame pending");
         end else begin
            check("framesDropped_at_init", int'(bus.framesDropped), init_exp_q.pop_front());
         end
      end
      prev_init <= bus.filterInit && !reset;
   end

   task automatic send_pix(input logic [7:0] p, input logic s, input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.pixIn    = p;
      bus.sof      = s;
      bus.pixValid = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 2000 && !bus.pixReady; g++) @(negedge clk);
      if (!bus.pixReady) give_up("pixReady");
      @(posedge clk);
      #1;
      bus.pixValid = 1'b0;
      bus.sof      = 1'b0;
   endtask

   task automatic send_range(input int pat, input int first, input int last, input int gap_max);
      for (int i = first; i <= last; i++)
         send_pix(pix_val(pat, i % W, i / W), i == 0, int'($urandom_range(gap_max)));
   endtask

   task automatic rd(input int pat, input int x, input int y);
      bus.rdX  = 8'(x);
      bus.rdY  = 8'(y);
      rd_issue = 1'b1;
      rd_exp_q.push_back(exp_read(pat, x, y));
      @(posedge clk);
      #1;
      rd_issue = 1'b0;
   endtask

   task automatic wait_init(input int n);
      for (int g = 0; g < 3000 && init_seen < n; g++) @(posedge clk);
      if (init_seen < n) give_up("filterInit");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #800000;
      give_up("watchdog");
   end

   initial begin
      reset        = 1'b1;
      bus.pixIn    = 8'd0;
      bus.pixValid = 1'b0;
      bus.sof      = 1'b0;
      bus.rdX      = 8'd0;
      bus.rdY      = 8'd0;
      @(posedge clk);
      @(negedge clk);
      check("rst_pixReady", int'(bus.pixReady), 0);
      check("rst_filterInit", int'(bus.filterInit), 0);
      check("rst_filterStart", int'(bus.filterStart), 0);
      check("rst_rdData", int'(bus.rdData), 0);
      check("rst_framesDropped", int'(bus.framesDropped), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", int'(bus.pixReady), 1);
      @(posedge clk);
      #1;

      // frame 1: sparse pattern, threshold edge and out-of-range reads
      send_range(0, 0, PIX - 1, 0);
      init_exp_q.push_back(0);
      wait_init(1);
      rd(0, 10, 20);
      rd(0, 11, 20);
      rd(0, 2, 3);
      rd(0, 3, 3);
      rd(0, 240, 20);
      rd(0, 10, 22);

      // frame 2 fills while the filter is still busy: writer must stall
      send_range(1, 0, PIX - 1, 0);
      check("stall_after_full", int'(bus.pixReady), 0);
      rd(0, 10, 20);
      rd(0, 3, 3);
      check("still_stalled", int'(bus.pixReady), 0);
      check("run_while_stalled", int'(bus.filterStart), 1);
      done_force = 1'b1;
      @(negedge clk);
      check("start_at_done", int'(bus.filterStart), 1);
      @(negedge clk);
      check("drain_hold", int'(bus.filterStart), 1);
      @(negedge clk);
      check("drain_fall", int'(bus.filterStart), 0);
      check("ready_after_release", int'(bus.pixReady), 1);
      done_force = 1'b0;
      init_exp_q.push_back(0);
      @(posedge clk);
      #1;
      wait_init(2);
      rd(1, 0, 0);
      rd(1, W - 1, H - 1);
      rd(1, 9, 3);
      rd(1, 10, 10);
      rd(1, 240, 0);
      rd(1, W, 9);
      rd(1, 5, H);

      // mid-frame sof abandons the partial frame and restarts it
      done_after = 40;
      send_range(2, 0, 99, 0);
      done_after = 300;
      send_pix(pix_val(2, 0, 0), 1'b1, 0);
      check("framesDropped_abort", int'(bus.framesDropped), 1);
      send_range(2, 1, PIX - 1, 0);
      init_exp_q.push_back(1);
      wait_init(3);
      rd(2, 5, 3);
      rd(2, 3, 5);
      rd(2, 4, 4);
      rd(2, 0, H - 1);
      rd(2, W - 1, H - 1);

      // gappy stream into the free bank while the read bank is being filtered
      fork
         send_range(3, 0, PIX - 1, 2);
         begin
            for (int k = 0; k < 40; k++)
               rd(2, int'($urandom_range(W - 1)), int'($urandom_range(H - 1)));
         end
      join
      init_exp_q.push_back(1);
      wait_init(4);
      done_after = 1000000;
      rd(3, 0, 0);
      rd(3, W - 1, 0);
      rd(3, 0, H - 1);
      rd(3, W - 1, H - 1);
      for (int k = 0; k < 16; k++)
         rd(3, int'($urandom_range(W - 1)), int'($urandom_range(H - 1)));

      // back-to-back sof transfers: each after the first is an abort
      send_pix(8'd200, 1'b1, 0);
      send_pix(8'd200, 1'b1, 0);
      send_pix(8'd200, 1'b1, 0);
      check("framesDropped_count", int'(bus.framesDropped), 3);
      for (int k = 0; k < 254; k++) send_pix(8'd200, 1'b1, 0);
      check("framesDropped_saturate", int'(bus.framesDropped), 255);

      // reset in the middle of a run and a partial write
      reset = 1'b1;
      @(negedge clk);
      check("midrst_pixReady", int'(bus.pixReady), 0);
      check("midrst_filterStart", int'(bus.filterStart), 0);
      check("midrst_filterInit", int'(bus.filterInit), 0);
      @(negedge clk);
      check("midrst_framesDropped", int'(bus.framesDropped), 0);
      check("midrst_filterStart2", int'(bus.filterStart), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("ready_after_midrst", int'(bus.pixReady), 1);
      @(posedge clk);
      #1;
      done_after = 50;
      send_range(0, 0, PIX - 1, 0);
      init_exp_q.push_back(0);
      wait_init(5);
      rd(0, 10, 20);
      rd(0, 0, 0);
      rd(0, 2, 3);
      rd(0, 3, 3);

      repeat (3) @(posedge clk);
      check("rd_queue_drained", rd_exp_q.size(), 0);
      check("init_queue_drained", init_exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
